powerup_spawner: RTL and testbench
==================================

// Module: powerup_spawner
// PURPOSE
//  Initiator side of the power-up interface: decides when and where a power-up appears and what type it is.
//  Detects ball/power-up overlap and issues the one-cycle eaten pulse and 2-bit mode that powerup_timer consumes.
//  Sits between the ball/paddle logic and powerup_timer; pu_visible/pu_x/pu_y feed the pixel generator.
// PARAMETERS
//  PRESCALER     64999999  clk cycles per second minus 1 (1 Hz tick when sec_cnt == PRESCALER)
//  RESPAWN_SEC   3         seconds from WAIT entry to spawn (8-bit, 0 treated as 1)
//  LIFETIME_SEC  8         seconds a spawned power-up stays before vanishing (8-bit, 0 treated as 1)
//  PU_SIZE       16        power-up square side, pixels
//  BALL_SIZE     8         ball square side, pixels
//  X_MIN         64        leftmost spawn x; pu_x = X_MIN + 9-bit offset
//  Y_MIN         48        top spawn y; pu_y = Y_MIN + 8-bit offset
//  LFSR_SEED     16'hACE1  LFSR reset value, must be non-zero
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high
//  game_active  in   1   high while a rally is in play
//  ball_x       in   10  ball top-left x
//  ball_y       in   10  ball top-left y
//  pu_visible   out  1   power-up drawn this cycle
//  pu_x         out  10  power-up top-left x
//  pu_y         out  10  power-up top-left y
//  eaten        out  1   one-cycle pulse on collection
//  mode         out  2   power-up type, stable from spawn until next spawn
//  warning      out  1   last 2 s of lifetime (0 when POWERUP_BLINK_EN undefined)
// BEHAVIOUR
//  Reset: state IDLE, pu_visible 0, pu_x X_MIN, pu_y Y_MIN, eaten 0, mode 0, warning 0, lfsr LFSR_SEED, sec_cnt 0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every non-reset cycle; never reaches zero.
//  Second timer: sec_cnt counts 0..PRESCALER, wraps to 0; tick = (sec_cnt == PRESCALER).
//   sec_cnt and sec_left both reload on every state entry; sec_left decrements on tick.
//   Timeout = tick while sec_left == 1; so N seconds = exactly N*(PRESCALER+1) cycles after entry.
//  FSM:
//   IDLE   : game_active=1 -> WAIT (sec_left <= RESPAWN_SEC).
//   WAIT   : timeout -> ACTIVE; same edge latches pu_x <= X_MIN+lfsr[15:7], pu_y <= Y_MIN+lfsr[7:0],
//            mode <= lfsr[3:2], pu_visible <= 1, sec_left <= LIFETIME_SEC.
//   ACTIVE : hit -> WAIT with eaten <= 1 for exactly one cycle, pu_visible <= 0; mode unchanged during pulse.
//            timeout without hit -> WAIT, pu_visible <= 0, no eaten.
//  hit (combinational, unsigned 11-bit compares): ball_x < pu_x+PU_SIZE && ball_x+BALL_SIZE > pu_x
//   && ball_y < pu_y+PU_SIZE && ball_y+BALL_SIZE > pu_y.
//  Priority: reset > game_active=0 (-> IDLE, pu_visible 0, eaten 0, counters cleared) > hit > timeout.
//  Hit and timeout on same edge: hit wins, eaten pulses. eaten is never asserted outside ACTIVE->WAIT edge.
//  eaten cannot repeat: after the pulse state is WAIT, so a ball resting on the old location gives no second pulse.
//  Reset or game_active drop mid-WAIT/ACTIVE: no eaten; re-entry starts a full RESPAWN_SEC wait.
// CONFIGURATION
//  POWERUP_BLINK_EN defined: warning = ACTIVE && sec_left <= 2; while warning, pu_visible = 1 only when
//   sec_cnt <= PRESCALER/2 (blinks at 1 Hz, 50%); hit detection is unaffected by blink phase.
//  POWERUP_BLINK_EN undefined: warning tied 0; pu_visible solid for whole ACTIVE period.
// TESTING (PRESCALER=9, RESPAWN_SEC=3, LIFETIME_SEC=4, ball parked at (0,0) unless stated)
//  1 reset, then game_active=1 -> IDLE->WAIT next edge; pu_visible rises exactly 30 cycles later;
//    64<=pu_x<=575, 48<=pu_y<=303; pu_x/pu_y/mode equal LFSR-derived values of the spawn cycle.
//  2 during ACTIVE drive ball_x=pu_x+4, ball_y=pu_y+4 -> eaten=1 for one cycle, pu_visible=0 same cycle,
//    mode unchanged; keep ball there -> no further eaten; next spawn 30 cycles after pulse.
//  3 no collision -> pu_visible falls 40 cycles after spawn, eaten stays 0; respawn 30 cycles later.
//  4 drive ball onto power-up on exactly the timeout cycle -> eaten pulses once.
//  5 game_active=0 mid-ACTIVE -> pu_visible 0 next cycle, no eaten; reassert -> full 30-cycle wait;
//    repeat with reset mid-WAIT -> all outputs at reset values, lfsr=16'hACE1.
//  6 POWERUP_BLINK_EN: warning=1 for final 20 cycles of lifetime; pu_visible high cycles 0-4, low 5-9
//    of each second; hit during low phase still pulses eaten. Undefined: warning=0, no blinking.

Source files
------------

// File: rtl/powerup_spawner.sv
// Power-up spawner: picks spawn time/place/type, detects ball pickup, drives the eaten pulse + mode.
// Latency: spawn exactly RESPAWN_SEC*(PRESCALER+1) cycles after WAIT entry; eaten registered, one cycle after the overlapping edge.
// No backpressure: eaten is a fire-and-forget one-cycle strobe; optional blink warning under `ifdef POWERUP_BLINK_EN.
module powerup_spawner #(
   parameter int unsigned PRESCALER    = 64999999,
   parameter int unsigned RESPAWN_SEC  = 3,
   parameter int unsigned LIFETIME_SEC = 8,
   parameter int unsigned PU_SIZE      = 16,
   parameter int unsigned BALL_SIZE    = 8,
   parameter int unsigned X_MIN        = 64,
   parameter int unsigned Y_MIN        = 48,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_active,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   output logic       pu_visible,
   output logic [9:0] pu_x,
   output logic [9:0] pu_y,
   output logic       eaten,
   output logic [1:0] mode,
   output logic       warning
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int unsigned CNT_W = (PRESCALER == 0) ? 1 : $clog2(PRESCALER + 1);

   localparam logic [CNT_W-1:0] PRESC_C = CNT_W'(PRESCALER);

   // Second counts of zero would never time out; they behave as one second.
   localparam logic [7:0] RESP_RAW = 8'(RESPAWN_SEC);
   localparam logic [7:0] LIFE_RAW = 8'(LIFETIME_SEC);
   localparam logic [7:0] RESP_C   = (RESP_RAW == 8'd0) ? 8'd1 : RESP_RAW;
   localparam logic [7:0] LIFE_C   = (LIFE_RAW == 8'd0) ? 8'd1 : LIFE_RAW;

   localparam logic [9:0]  X_MIN_C   = 10'(X_MIN);
   localparam logic [9:0]  Y_MIN_C   = 10'(Y_MIN);
   localparam logic [10:0] PU_SZ_C   = 11'(PU_SIZE);
   localparam logic [10:0] BALL_SZ_C = 11'(BALL_SIZE);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]       state_q,    state_d;
   logic [CNT_W-1:0] sec_cnt_q,  sec_cnt_d;
   logic [7:0]       sec_left_q, sec_left_d;
   logic [15:0]      lfsr_q,     lfsr_d;
   logic [9:0]       pu_x_q,     pu_x_d;
   logic [9:0]       pu_y_q,     pu_y_d;
   logic [1:0]       mode_q,     mode_d;
   logic             pu_vis_q,   pu_vis_d;
   logic             eaten_q,    eaten_d;

   // ------------------------------------------------------------------
   // Derived strobes
   // ------------------------------------------------------------------
   logic        tick;
   logic        timeout;
   logic        lfsr_fb;
   logic        hit;
   logic [10:0] bx_w, by_w, px_w, py_w;

   // Fibonacci taps 16,14,13,11 on a left-shifting register; seed is non-zero so zero is unreachable.
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   assign tick    = (sec_cnt_q == PRESC_C);
   assign timeout = tick && (sec_left_q == 8'd1);

   // Widen to 11 bits so the right/bottom edges never wrap at the top of the 10-bit range.
   assign bx_w = {1'b0, ball_x};
   assign by_w = {1'b0, ball_y};
   assign px_w = {1'b0, pu_x_q};
   assign py_w = {1'b0, pu_y_q};

   // Axis-aligned square overlap; independent of blink phase.
   assign hit = (bx_w < px_w + PU_SZ_C) && (bx_w + BALL_SZ_C > px_w) &&
                (by_w < py_w + PU_SZ_C) && (by_w + BALL_SZ_C > py_w);

   // Next-state: free-running second timer, then FSM transitions which reload the timer on entry.
   always_comb begin
      state_d    = state_q;
      sec_cnt_d  = sec_cnt_q;
      sec_left_d = sec_left_q;
      pu_x_d     = pu_x_q;
      pu_y_d     = pu_y_q;
      mode_d     = mode_q;
      pu_vis_d   = pu_vis_q;
      eaten_d    = 1'b0;
      lfsr_d     = {lfsr_q[14:0], lfsr_fb};

      if (tick) begin
         sec_cnt_d = '0;
         if (sec_left_q != 8'd0) begin
            sec_left_d = sec_left_q - 8'd1;
         end
      end else begin
         sec_cnt_d = sec_cnt_q + CNT_W'(1);
      end

      if (!game_active) begin
         // Rally over: drop everything, no pickup credit even if the ball overlaps.
         state_d    = ST_IDLE;
         pu_vis_d   = 1'b0;
         sec_cnt_d  = '0;
         sec_left_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d    = ST_WAIT;
               sec_cnt_d  = '0;
               sec_left_d = RESP_C;
            end
            ST_WAIT: begin
               if (timeout) begin
                  state_d    = ST_ACTIVE;
                  pu_x_d     = X_MIN_C + {1'b0, lfsr_q[15:7]};
                  pu_y_d     = Y_MIN_C + {2'b00, lfsr_q[7:0]};
                  mode_d     = lfsr_q[3:2];
                  pu_vis_d   = 1'b1;
                  sec_cnt_d  = '0;
                  sec_left_d = LIFE_C;
               end
            end
            ST_ACTIVE: begin
               // Pickup outranks expiry on the same edge.
               if (hit) begin
                  state_d    = ST_WAIT;
                  eaten_d    = 1'b1;
                  pu_vis_d   = 1'b0;
                  sec_cnt_d  = '0;
                  sec_left_d = RESP_C;
               end else if (timeout) begin
                  state_d    = ST_WAIT;
                  pu_vis_d   = 1'b0;
                  sec_cnt_d  = '0;
                  sec_left_d = RESP_C;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               pu_vis_d   = 1'b0;
               sec_cnt_d  = '0;
               sec_left_d = 8'd0;
            end
         endcase
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sec_cnt_q  <= '0;
         sec_left_q <= 8'd0;
         lfsr_q     <= LFSR_SEED;
         pu_x_q     <= X_MIN_C;
         pu_y_q     <= Y_MIN_C;
         mode_q     <= 2'd0;
         pu_vis_q   <= 1'b0;
         eaten_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sec_cnt_q  <= sec_cnt_d;
         sec_left_q <= sec_left_d;
         lfsr_q     <= lfsr_d;
         pu_x_q     <= pu_x_d;
         pu_y_q     <= pu_y_d;
         mode_q     <= mode_d;
         pu_vis_q   <= pu_vis_d;
         eaten_q    <= eaten_d;
      end
   end

   assign pu_x  = pu_x_q;
   assign pu_y  = pu_y_q;
   assign mode  = mode_q;
   assign eaten = eaten_q;

`ifdef POWERUP_BLINK_EN
   localparam logic [CNT_W-1:0] HALF_C = CNT_W'(PRESCALER / 2);

   // Final two seconds: flash at 1 Hz, lit for the first half of each second.
   assign warning    = (state_q == ST_ACTIVE) && (sec_left_q <= 8'd2);
   assign pu_visible = pu_vis_q && (!warning || (sec_cnt_q <= HALF_C));
`else
   assign warning    = 1'b0;
   assign pu_visible = pu_vis_q;
`endif

endmodule

// File: tb/tb_powerup_spawner.sv
// Testbench for powerup_spawner: scoreboarded spawn position/time checks, pickup, expiry, drop and reset.
// Runs with PRESCALER=9, RESPAWN_SEC=3, LIFETIME_SEC=4; blink expectations follow POWERUP_BLINK_EN.
// Inputs driven and outputs sampled on the falling edge.
module tb_powerup_spawner;

   localparam logic [15:0] SEED = 16'hACE1;
`ifdef POWERUP_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       game_active = 1'b0;
   logic [9:0] ball_x = 10'd0;
   logic [9:0] ball_y = 10'd0;
   logic       pu_visible;
   logic [9:0] pu_x;
   logic [9:0] pu_y;
   logic       eaten;
   logic [1:0] mode;
   logic       warning;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int cyc;
      int x;
      int y;
      int mode;
   } spawn_t;

   spawn_t sb_q[$];

   int          cyc    = 0;
   logic [15:0] m_lfsr = SEED;

   powerup_spawner #(
      .PRESCALER(9),
      .RESPAWN_SEC(3),
      .LIFETIME_SEC(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .game_active(game_active),
      .ball_x(ball_x),
      .ball_y(ball_y),
      .pu_visible(pu_visible),
      .pu_x(pu_x),
      .pu_y(pu_y),
      .eaten(eaten),
      .mode(mode),
      .warning(warning)
   );

   always #5 clk = ~clk;

   // Reference LFSR and edge counter, advanced on the same edges as the design.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) m_lfsr <= SEED;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
      return r;
   endfunction

   function automatic spawn_t mk_spawn(input int at, input logic [15:0] v);
      spawn_t s;
      s.cyc  = at;
      s.x    = 64 + int'(v[15:7]);
      s.y    = 48 + int'(v[7:0]);
      s.mode = int'(v[3:2]);
      return s;
   endfunction

   // Steps falling edges until the chosen output equals want; at = -1 if the budget runs out.
   task automatic wait_for(input bit on_eaten, input logic want, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((on_eaten ? eaten : pu_visible) === want) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      game_active = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_tests++; if (pu_visible !== 1'b0) begin n_fail++; $display("FAIL rst_vis: got %b want 0", pu_visible); end
      n_tests++; if (pu_x !== 10'd64) begin n_fail++; $display("FAIL rst_pu_x: got %0d want 64", pu_x); end
      n_tests++; if (pu_y !== 10'd48) begin n_fail++; $display("FAIL rst_pu_y: got %0d want 48", pu_y); end
      n_tests++; if (eaten !== 1'b0) begin n_fail++; $display("FAIL rst_eaten: got %b want 0", eaten); end
      n_tests++; if (mode !== 2'd0) begin n_fail++; $display("FAIL rst_mode: got %0d want 0", mode); end
      n_tests++; if (warning !== 1'b0) begin n_fail++; $display("FAIL rst_warning: got %b want 0", warning); end
      n_tests++; if (dut.lfsr_q !== SEED) begin n_fail++; $display("FAIL rst_lfsr: got %h want %h", dut.lfsr_q, SEED); end
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if (pu_visible !== 1'b0) begin n_fail++; $display("FAIL idle_vis: got %b want 0", pu_visible); end
   endtask

   task automatic test_spawn();
      spawn_t e;
      int at;
      sb_q.push_back(mk_spawn(cyc + 31, lfsr_adv(m_lfsr, 30)));
      game_active = 1'b1;
      wait_for(1'b0, 1'b1, 60, at);
      e = sb_q.pop_front();
      n_tests++; if (at !== e.cyc) begin n_fail++; $display("FAIL spawn_time: rose at %0d want %0d", at, e.cyc); end
      n_tests++; if (pu_x !== 10'(e.x)) begin n_fail++; $display("FAIL spawn_x: got %0d want %0d", pu_x, e.x); end
      n_tests++; if (pu_y !== 10'(e.y)) begin n_fail++; $display("FAIL spawn_y: got %0d want %0d", pu_y, e.y); end
      n_tests++; if (mode !== 2'(e.mode)) begin n_fail++; $display("FAIL spawn_mode: got %0d want %0d", mode, e.mode); end
      n_tests++;
      if (!(pu_x >= 10'd64 && pu_x <= 10'd575 && pu_y >= 10'd48 && pu_y <= 10'd303)) begin
         n_fail++; $display("FAIL spawn_range: got (%0d,%0d) want x 64..575 y 48..303", pu_x, pu_y);
      end
   endtask

   task automatic test_hit();
      spawn_t e;
      int p, at, extra;
      logic [1:0] m0;
      m0 = mode;
      ball_x = pu_x + 10'd4;
      ball_y = pu_y + 10'd4;
      @(negedge clk);
      p = cyc;
      n_tests++; if (eaten !== 1'b1) begin n_fail++; $display("FAIL hit_eaten: got %b want 1", eaten); end
      n_tests++; if (pu_visible !== 1'b0) begin n_fail++; $display("FAIL hit_vis: got %b want 0", pu_visible); end
      n_tests++; if (mode !== m0) begin n_fail++; $display("FAIL hit_mode: got %0d want %0d", mode, m0); end
      sb_q.push_back(mk_spawn(p + 30, lfsr_adv(m_lfsr, 29)));
      @(negedge clk);
      n_tests++; if (eaten !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_len: got %b want 0", eaten); end
      extra = 0;
      at = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (eaten === 1'b1) extra++;
         if (pu_visible === 1'b1) begin at = cyc; break; end
      end
      ball_x = 10'd0;
      ball_y = 10'd0;
      e = sb_q.pop_front();
      n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL hit_no_repeat: got %0d extra pulses want 0", extra); end
      n_tests++; if (at !== e.cyc) begin n_fail++; $display("FAIL hit_respawn_time: rose at %0d want %0d", at, e.cyc); end
      n_tests++; if (pu_x !== 10'(e.x) || pu_y !== 10'(e.y)) begin
         n_fail++; $display("FAIL hit_respawn_pos: got (%0d,%0d) want (%0d,%0d)", pu_x, pu_y, e.x, e.y);
      end
   endtask

   task automatic test_timeout();
      spawn_t e;
      int s, at, bad_vis, bad_warn, eat;
      bit exp_v, exp_w;
      s = cyc;
      bad_vis = 0; bad_warn = 0; eat = 0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         exp_v = BLINK ? !(k >= 20 && (k % 10) >= 5) : 1'b1;
         exp_w = BLINK && (k >= 20);
         if (pu_visible !== exp_v) bad_vis++;
         if (warning !== exp_w) bad_warn++;
         if (eaten !== 1'b0) eat++;
      end
      @(negedge clk);
      if (eaten !== 1'b0) eat++;
      n_tests++; if (pu_visible !== 1'b0) begin n_fail++; $display("FAIL expire_vis: got %b want 0 at spawn+40", pu_visible); end
      n_tests++; if (bad_vis !== 0) begin n_fail++; $display("FAIL life_vis_pattern: %0d cycles wrong want 0", bad_vis); end
      n_tests++; if (bad_warn !== 0) begin n_fail++; $display("FAIL life_warning: %0d cycles wrong want 0", bad_warn); end
      n_tests++; if (eat !== 0) begin n_fail++; $display("FAIL expire_eaten: got %0d pulses want 0", eat); end
      sb_q.push_back(mk_spawn(s + 70, lfsr_adv(m_lfsr, 29)));
      wait_for(1'b0, 1'b1, 40, at);
      e = sb_q.pop_front();
      n_tests++; if (at !== e.cyc) begin n_fail++; $display("FAIL expire_respawn_time: rose at %0d want %0d", at, e.cyc); end
      n_tests++; if (mode !== 2'(e.mode)) begin n_fail++; $display("FAIL expire_respawn_mode: got %0d want %0d", mode, e.mode); end
   endtask

   task automatic test_hit_at_timeout();
      spawn_t e;
      int s, at;
      s = cyc;
      for (int i = 0; i < 39; i++) @(negedge clk);
      ball_x = pu_x + 10'd4;
      ball_y = pu_y + 10'd4;
      @(negedge clk);
      ball_x = 10'd0;
      ball_y = 10'd0;
      n_tests++; if (eaten !== 1'b1) begin n_fail++; $display("FAIL edge_hit_eaten: got %b want 1 at cycle %0d", eaten, cyc - s); end
      n_tests++; if (pu_visible !== 1'b0) begin n_fail++; $display("FAIL edge_hit_vis: got %b want 0", pu_visible); end
      sb_q.push_back(mk_spawn(s + 70, lfsr_adv(m_lfsr, 29)));
      @(negedge clk);
      n_tests++; if (eaten !== 1'b0) begin n_fail++; $display("FAIL edge_hit_once: got %b want 0", eaten); end
      wait_for(1'b0, 1'b1, 40, at);
      e = sb_q.pop_front();
      n_tests++; if (at !== e.cyc) begin n_fail++; $display("FAIL edge_respawn_time: rose at %0d want %0d", at, e.cyc); end
      n_tests++; if (pu_x !== 10'(e.x) || pu_y !== 10'(e.y)) begin
         n_fail++; $display("FAIL edge_respawn_pos: got (%0d,%0d) want (%0d,%0d)", pu_x, pu_y, e.x, e.y);
      end
   endtask

   task automatic test_game_drop();
      spawn_t e;
      int at, bad;
      for (int i = 0; i < 3; i++) @(negedge clk);
      ball_x = pu_x + 10'd4;
      ball_y = pu_y + 10'd4;
      game_active = 1'b0;
      @(negedge clk);
      ball_x = 10'd0;
      ball_y = 10'd0;
      n_tests++; if (pu_visible !== 1'b0) begin n_fail++; $display("FAIL drop_vis: got %b want 0", pu_visible); end
      n_tests++; if (eaten !== 1'b0) begin n_fail++; $display("FAIL drop_eaten: got %b want 0", eaten); end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (eaten !== 1'b0 || pu_visible !== 1'b0) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL drop_idle: %0d cycles active want 0", bad); end
      sb_q.push_back(mk_spawn(cyc + 31, lfsr_adv(m_lfsr, 30)));
      game_active = 1'b1;
      wait_for(1'b0, 1'b1, 60, at);
      e = sb_q.pop_front();
      n_tests++; if (at !== e.cyc) begin n_fail++; $display("FAIL drop_respawn_time: rose at %0d want %0d", at, e.cyc); end
      n_tests++; if (mode !== 2'(e.mode)) begin n_fail++; $display("FAIL drop_respawn_mode: got %0d want %0d", mode, e.mode); end
   endtask

   task automatic test_reset_mid_wait();
      spawn_t e;
      int at;
      ball_x = pu_x + 10'd4;
      ball_y = pu_y + 10'd4;
      @(negedge clk);
      ball_x = 10'd0;
      ball_y = 10'd0;
      n_tests++; if (eaten !== 1'b1) begin n_fail++; $display("FAIL prerst_eaten: got %b want 1", eaten); end
      for (int i = 0; i < 5; i++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_tests++; if (pu_visible !== 1'b0 || eaten !== 1'b0 || warning !== 1'b0) begin
         n_fail++; $display("FAIL midrst_flags: got vis %b eaten %b warn %b want 0 0 0", pu_visible, eaten, warning);
      end
      n_tests++; if (pu_x !== 10'd64 || pu_y !== 10'd48 || mode !== 2'd0) begin
         n_fail++; $display("FAIL midrst_pos: got (%0d,%0d) mode %0d want (64,48) mode 0", pu_x, pu_y, mode);
      end
      n_tests++; if (dut.lfsr_q !== SEED) begin n_fail++; $display("FAIL midrst_lfsr: got %h want %h", dut.lfsr_q, SEED); end
      sb_q.push_back(mk_spawn(cyc + 31, lfsr_adv(SEED, 30)));
      reset = 1'b0;
      wait_for(1'b0, 1'b1, 60, at);
      e = sb_q.pop_front();
      n_tests++; if (at !== e.cyc) begin n_fail++; $display("FAIL postrst_time: rose at %0d want %0d", at, e.cyc); end
      n_tests++; if (pu_x !== 10'(e.x) || pu_y !== 10'(e.y) || mode !== 2'(e.mode)) begin
         n_fail++; $display("FAIL postrst_spawn: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", pu_x, pu_y, mode, e.x, e.y, e.mode);
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_hit();
      test_timeout();
      test_hit_at_timeout();
      test_game_drop();
      test_reset_mid_wait();
      n_tests++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: %0d entries want 0", sb_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d checks done", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
